data_sram_like_bridge: RTL and testbench
========================================

# data_sram_like_bridge

Data-side bus bridge sitting directly downstream of the address-translation stage. It takes the MEM-stage data access (physical address already translated), issues it as a single sram-like transaction (req / addr_ok / data_ok), stalls the pipeline until the transaction completes, and holds the load result until the pipeline releases the instruction. It handles exactly one outstanding access at a time.

## Interface
- none; address and data widths are fixed at 32 bits.

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- data_en  in  1  MEM stage holds a load/store this cycle
- data_wen  in  4  byte write strobes; 4'b0000 = load, nonzero = store
- data_paddr  in  32  translated physical address
- data_wdata  in  32  store data, already byte-lane aligned
- data_size  in  2  0 = byte, 1 = half, 2 = word; 3 reserved
- cpu_stall_all  in  1  pipeline frozen by any source (including this block)
- data_rdata  out  32  load result, valid in DONE and held afterwards
- d_stall  out  1  request to freeze pipeline
- bus_req  out  1  sram-like request
- bus_wr  out  1  1 = write
- bus_size  out  2  access size
- bus_addr  out  32  access address
- bus_wdata  out  32  write data
- bus_addr_ok  in  1  request accepted
- bus_data_ok  in  1  data returned / write complete
- bus_rdata  in  32  read data, valid with bus_data_ok

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE: if data_en=1 -> latch data_paddr, data_wdata, data_size, (|data_wen) into request registers; go ADDR. Otherwise stay.
- ADDR: bus_req=1, bus_* driven from request registers (stable until accepted). bus_addr_ok=1 -> DATA; else stay. bus_data_ok in ADDR is ignored.
- DATA: bus_req=0. bus_data_ok=1 -> if request was a load, data_rdata <= bus_rdata; go DONE. Stores leave data_rdata unchanged.
- DONE: access complete. cpu_stall_all=0 -> IDLE (instruction retires at this edge); cpu_stall_all=1 -> stay, data_rdata held.
- d_stall = data_en & (state != DONE), combinational.
- bus_wr = latched |data_wen; bus_size = latched data_size; no alignment checking (exceptions are raised upstream).
- bus_data_ok while in IDLE or DONE is ignored.
- No buffering: a new access is accepted only from IDLE, so back-to-back accesses cost one IDLE cycle between them.

## Timing
- Reset values: state=IDLE, bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wdata=0, data_rdata=0; d_stall then follows data_en.
- rst in any state -> IDLE next edge; request registers and data_rdata cleared; an in-flight bus transaction is abandoned and its late data_ok ignored.
- Minimum latency (addr_ok in first ADDR cycle, data_ok next cycle): data_en at cycle 0; bus_req at cycle 1; DATA at cycle 2; DONE at cycle 3 with d_stall=0 and data_rdata valid. 3 stall cycles.
- Each cycle of addr_ok or data_ok delay adds one stall cycle.
- bus_req is a registered-state output: never asserted in the same cycle data_en first rises.
- data_rdata is a register; it changes only on the edge that captures bus_data_ok in DATA, or on rst.

## Test plan
- Load, addr_ok in first ADDR cycle, data_ok one cycle later with bus_rdata=32'hDEADBEEF, paddr=32'h1FC0_0010, size=2 -> bus_req high exactly 1 cycle with bus_addr=32'h1FC0_0010, bus_wr=0; d_stall high cycles 0-2; data_rdata=32'hDEADBEEF at cycle 3.
- addr_ok delayed 3 cycles, data_ok delayed 2 more -> bus_req high 4 cycles with stable bus_addr/bus_size; d_stall high 7 cycles; single transaction only.
- Store, data_wen=4'b0011, size=1, wdata=32'h0000_ABCD -> bus_wr=1, bus_size=1, bus_wdata=32'h0000_ABCD; data_rdata unchanged from prior value.
- Load completes while cpu_stall_all=1 for 4 cycles in DONE -> state stays DONE, d_stall=0, data_rdata stable; no new bus_req until cpu_stall_all falls and a fresh data_en is seen in IDLE.
- rst asserted in DATA, then bus_data_ok arrives one cycle after reset -> outputs return to reset values, data_rdata stays 0, data_ok ignored.
- Two consecutive loads (data_en held across retire) -> second bus_req starts one cycle after returning to IDLE; each captures its own rdata.

Source files
------------

// File: rtl/data_sram_like_bridge.sv
// Data-side sram-like bridge: issues one MEM-stage access as a single req/addr_ok/data_ok
// transaction, stalls the pipeline until it completes and holds the load result afterwards.
module data_sram_like_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_paddr,
  input  logic [31:0] data_wdata,
  input  logic [1:0]  data_size,
  input  logic        cpu_stall_all,
  output logic [31:0] data_rdata,
  output logic        d_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_wr_q, bus_wr_d;
  logic [1:0]  bus_size_q, bus_size_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  // Next-state and request-register logic; bus_data_ok outside DATA is deliberately dropped.
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_size_d   = bus_size_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (data_en) begin
          state_d     = ADDR;
          bus_req_d   = 1'b1;
          bus_wr_d    = |data_wen;
          bus_size_d  = data_size;
          bus_addr_d  = data_paddr;
          bus_wdata_d = data_wdata;
        end else begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          state_d   = DATA;
          bus_req_d = 1'b0;
        end else begin
          state_d   = ADDR;
          bus_req_d = 1'b1;
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          state_d = DONE;
          if (!bus_wr_q) begin
            data_rdata_d = bus_rdata;
          end else begin
            data_rdata_d = data_rdata_q;
          end
        end else begin
          state_d = DATA;
        end
      end
      DONE: begin
        if (!cpu_stall_all) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_size_q   <= 2'd0;
      bus_addr_q   <= 32'd0;
      bus_wdata_q  <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_size_q   <= bus_size_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Stall drops in DONE so the pipeline can sample data_rdata and retire.
  assign d_stall    = data_en & (state_q != DONE);
  assign bus_req    = bus_req_q;
  assign bus_wr     = bus_wr_q;
  assign bus_size   = bus_size_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Self-checking bench: directed vector table, hand-written reset corner case, and
// randomized accesses checked against a transaction-level model of the bridge.
module tb_data_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_paddr;
  logic [31:0] data_wdata;
  logic [1:0]  data_size;
  logic        cpu_stall_all;
  logic [31:0] data_rdata;
  logic        d_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_rdata_m;

  always #5 clk = ~clk;

  data_sram_like_bridge dut (
    .clk(clk), .rst(rst), .data_en(data_en), .data_wen(data_wen),
    .data_paddr(data_paddr), .data_wdata(data_wdata), .data_size(data_size),
    .cpu_stall_all(cpu_stall_all), .data_rdata(data_rdata), .d_stall(d_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ad;
    int          dd;
    int          hold;
    int          exp_stall;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete access: IDLE cycle with data_en, bus responder with given delays, DONE hold.
  task automatic access(input logic [31:0] addr, input logic [3:0] wen, input logic [1:0] size,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int ad,
                        input int dd, input int hold, input int exp_stall,
                        input logic [31:0] exp_rd);
    int stall_cnt, req_cycles, wait_cnt;
    bit accepted, done;
    logic [31:0] old_rd;
    old_rd = exp_rdata_m;
    @(negedge clk);
    data_en = 1'b1; data_wen = wen; data_paddr = addr; data_wdata = wdata; data_size = size;
    cpu_stall_all = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    #1;
    chk("req_first_cycle", 32'(bus_req), 32'd0);
    stall_cnt = d_stall ? 1 : 0;
    accepted = 1'b0; done = 1'b0; req_cycles = 0; wait_cnt = 0;
    for (int c = 1; c < 80 && !done; c++) begin
      @(negedge clk);
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
      data_paddr = $urandom; data_wdata = $urandom; data_size = 2'($urandom_range(0, 3));
      #1;
      if (!d_stall) begin
        done = 1'b1;
      end else begin
        stall_cnt++;
        chk("rdata_held_in_flight", data_rdata, old_rd);
        if (bus_req) begin
          chk("req_after_accept", 32'(accepted), 32'd0);
          req_cycles++;
          chk("bus_addr", bus_addr, addr);
          chk("bus_wr", 32'(bus_wr), 32'(|wen));
          chk("bus_size", 32'(bus_size), 32'(size));
          if (wen != 4'b0000) chk("bus_wdata", bus_wdata, wdata);
          if (req_cycles == ad + 1) begin
            bus_addr_ok = 1'b1;
            accepted = 1'b1;
          end else begin
            bus_data_ok = 1'($urandom_range(0, 1));
          end
        end else if (accepted) begin
          if (wait_cnt == dd) begin
            bus_data_ok = 1'b1;
            bus_rdata = rdata;
          end
          wait_cnt++;
        end
      end
    end
    chk("completed_in_bound", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    chk("req_cycles", 32'(req_cycles), 32'(ad + 1));
    chk("rdata_done", data_rdata, exp_rd);
    exp_rdata_m = exp_rd;
    cpu_stall_all = (hold > 0);
    bus_data_ok = 1'($urandom_range(0, 1));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus_data_ok = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      #1;
      chk("hold_d_stall", 32'(d_stall), 32'd0);
      chk("hold_bus_req", 32'(bus_req), 32'd0);
      chk("hold_rdata", data_rdata, exp_rd);
      if (h == hold - 1) cpu_stall_all = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_en = 1'b0; bus_addr_ok = 1'b0;
      bus_data_ok = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      #1;
      chk("idle_d_stall", 32'(d_stall), 32'd0);
      chk("idle_bus_req", 32'(bus_req), 32'd0);
      chk("idle_rdata", data_rdata, exp_rdata_m);
    end
  endtask

  initial begin
    vecs[0] = '{32'h1FC0_0010, 4'b0000, 2'd2, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 3, 32'hDEAD_BEEF};
    vecs[1] = '{32'h8000_0104, 4'b0000, 2'd2, 32'h0, 32'h1357_9BDF, 3, 1, 0, 7, 32'h1357_9BDF};
    vecs[2] = '{32'h0000_2002, 4'b0011, 2'd1, 32'h0000_ABCD, 32'hBAD0_BAD0, 0, 2, 0, 5, 32'h1357_9BDF};
    vecs[3] = '{32'h0000_3000, 4'b0000, 2'd0, 32'h0, 32'hCAFE_F00D, 1, 0, 4, 4, 32'hCAFE_F00D};
    vecs[4] = '{32'h0000_4004, 4'b0000, 2'd2, 32'h0, 32'h1111_2222, 0, 0, 0, 3, 32'h1111_2222};
    vecs[5] = '{32'h0000_4008, 4'b0000, 2'd2, 32'h0, 32'h3333_4444, 0, 0, 0, 3, 32'h3333_4444};

    rst = 1'b1; data_en = 1'b0; data_wen = 4'd0; data_paddr = 32'd0; data_wdata = 32'd0;
    data_size = 2'd0; cpu_stall_all = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    bus_rdata = 32'd0; exp_rdata_m = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_wr", 32'(bus_wr), 32'd0);
    chk("rst_bus_size", 32'(bus_size), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("rst_d_stall_low", 32'(d_stall), 32'd0);
    data_en = 1'b1;
    #1;
    chk("rst_d_stall_follows", 32'(d_stall), 32'd1);
    @(negedge clk);
    rst = 1'b0; data_en = 1'b0;

    // Directed table; consecutive entries run back-to-back with data_en held across retire.
    for (int i = 0; i < 6; i++) begin
      access(vecs[i].addr, vecs[i].wen, vecs[i].size, vecs[i].wdata, vecs[i].rdata,
             vecs[i].ad, vecs[i].dd, vecs[i].hold, vecs[i].exp_stall, vecs[i].exp_rd);
    end
    idle_cycles(2);

    // Reset while in DATA, late data_ok arrives right after reset.
    @(negedge clk);
    data_en = 1'b1; data_wen = 4'b0000; data_paddr = 32'h0000_5000; data_size = 2'd2;
    #1;
    @(negedge clk);
    #1;
    chk("rstdata_req", 32'(bus_req), 32'd1);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    #1;
    chk("rstdata_in_data", 32'(bus_req), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; data_en = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    #1;
    chk("rstdata_bus_addr", bus_addr, 32'd0);
    chk("rstdata_bus_size", 32'(bus_size), 32'd0);
    chk("rstdata_rdata", data_rdata, 32'd0);
    chk("rstdata_d_stall", 32'(d_stall), 32'd0);
    @(negedge clk);
    bus_data_ok = 1'b0;
    #1;
    chk("rstdata_late_ok_ignored", data_rdata, 32'd0);
    chk("rstdata_no_req", 32'(bus_req), 32'd0);
    exp_rdata_m = 32'd0;

    // Randomized accesses against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, wd, rd;
      logic [3:0]  w;
      logic [1:0]  s;
      int          ad, dd, hold;
      a = $urandom; wd = $urandom; rd = $urandom;
      w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      s = 2'($urandom_range(0, 2));
      ad = $urandom_range(0, 4); dd = $urandom_range(0, 4); hold = $urandom_range(0, 3);
      access(a, w, s, wd, rd, ad, dd, hold, 3 + ad + dd, (w == 4'b0000) ? rd : exp_rdata_m);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
